// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared encodings for the execute-stage hazard/forwarding controller.
package exe_hazard_ctrl_pkg;

  // Default register-index width.
  localparam int unsigned REG_W = 5;

  // Register 0 is hard-wired: never forwarded, never a stall source.
  localparam int unsigned REG_ZERO = 0;

  typedef logic [1:0] sel_t;

  // ALU operand select encodings.
  localparam sel_t SEL_REG = 2'b00;  // register file value
  localparam sel_t SEL_IMM = 2'b01;  // shift amount (A) or immediate (B)
  localparam sel_t SEL_MEM = 2'b10;  // forwarded from MEM-stage ALU result
  localparam sel_t SEL_WB  = 2'b11;  // forwarded from WB-stage memory/ALU result

endpackage

// File: rtl/exe_hazard_ctrl_fwd_sel.sv
// Per-operand ALU source selector: override first, then nearest producer.
module exe_hazard_ctrl_fwd_sel #(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] r_i,
  input  logic             use_i,
  input  logic             override_i,
  input  logic             hit_ex_i,
  input  logic             hit_mem_i,
  output logic [1:0]       sel_o
);
  import exe_hazard_ctrl_pkg::*;

  // Hits arrive as raw destination matches; the r0 exclusion is applied here.
  always_comb begin
    sel_o = SEL_REG;
    if (override_i) begin
      sel_o = SEL_IMM;
    end else if (use_i && (r_i != REG_W'(REG_ZERO))) begin
      if (hit_ex_i) begin
        sel_o = SEL_MEM;
      end else if (hit_mem_i) begin
        sel_o = SEL_WB;
      end
    end
  end

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Execute-stage hazard and forwarding controller: load-use stall, branch
// flush, registered ALU operand selects and saturating event counters.
module exe_hazard_ctrl #(
  parameter int unsigned REG_W = exe_hazard_ctrl_pkg::REG_W,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             id_shift,
  input  logic             id_aluimm,
  input  logic             exe_z,
  output logic [1:0]       exe_adepen,
  output logic [1:0]       exe_bdepen,
  output logic             stall,
  output logic             flush,
  output logic             id_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  import exe_hazard_ctrl_pkg::*;

  localparam logic [REG_W-1:0] Zero = REG_W'(REG_ZERO);

  // Shadow copies of the downstream destination registers.
  logic             ex_wreg;
  logic             ex_m2reg;
  logic [REG_W-1:0] ex_rd;
  logic             mem_wreg;
  logic [REG_W-1:0] mem_rd;

  // Raw destination matches, r0 not yet excluded.
  logic match_ex_rs, match_ex_rt, match_mem_rs, match_mem_rt;
  logic load_use;
  logic [1:0] sel_a, sel_b;

  // Producer matches and stall/flush/bubble decode; all quiet during reset.
  always_comb begin
    match_ex_rs  = ex_wreg && (ex_rd == id_rs);
    match_ex_rt  = ex_wreg && (ex_rd == id_rt);
    match_mem_rs = mem_wreg && (mem_rd == id_rs);
    match_mem_rt = mem_wreg && (mem_rd == id_rt);
    load_use = ex_m2reg &&
               ((id_use_rs && match_ex_rs && (id_rs != Zero)) ||
                (id_use_rt && match_ex_rt && (id_rt != Zero)));
    flush     = !rst && exe_z;
    // A stalled instruction behind a taken branch is wrong-path: flush wins.
    stall     = !rst && !exe_z && load_use;
    id_bubble = stall || flush;
  end

  exe_hazard_ctrl_fwd_sel #(
    .REG_W (REG_W)
  ) u_fwd_a (
    .r_i        (id_rs),
    .use_i      (id_use_rs),
    .override_i (id_shift),
    .hit_ex_i   (match_ex_rs),
    .hit_mem_i  (match_mem_rs),
    .sel_o      (sel_a)
  );

  exe_hazard_ctrl_fwd_sel #(
    .REG_W (REG_W)
  ) u_fwd_b (
    .r_i        (id_rt),
    .use_i      (id_use_rt),
    .override_i (id_aluimm),
    .hit_ex_i   (match_ex_rt),
    .hit_mem_i  (match_mem_rt),
    .sel_o      (sel_b)
  );

  // ID/EXE and EXE/MEM shadow state plus registered operand selects.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_wreg    <= 1'b0;
      ex_m2reg   <= 1'b0;
      ex_rd      <= '0;
      mem_wreg   <= 1'b0;
      mem_rd     <= '0;
      exe_adepen <= SEL_REG;
      exe_bdepen <= SEL_REG;
    end else begin
      // EXE always drains into MEM, even while ID is held.
      mem_wreg <= ex_wreg;
      mem_rd   <= ex_rd;
      if (id_bubble) begin
        ex_wreg    <= 1'b0;
        ex_m2reg   <= 1'b0;
        exe_adepen <= SEL_REG;
        exe_bdepen <= SEL_REG;
      end else begin
        ex_wreg    <= id_wreg;
        ex_m2reg   <= id_m2reg;
        ex_rd      <= id_rd;
        exe_adepen <= sel_a;
        exe_bdepen <= sel_b;
      end
    end
  end

  // Saturating stall/flush event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Randomized and directed bench for exe_hazard_ctrl against a pipeline-slot model.
module tb_exe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       use_rs;
    logic       use_rt;
    logic       wreg;
    logic       m2reg;
    logic       shift;
    logic       aluimm;
    logic       z;
    logic       rst;
  } id_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_use_rs, id_use_rt, id_wreg, id_m2reg, id_shift, id_aluimm, exe_z;
  logic [1:0]  exe_adepen, exe_bdepen;
  logic        stall, flush, id_bubble;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exe_hazard_ctrl #(
    .REG_W (5),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .id_wreg    (id_wreg),
    .id_m2reg   (id_m2reg),
    .id_shift   (id_shift),
    .id_aluimm  (id_aluimm),
    .exe_z      (exe_z),
    .exe_adepen (exe_adepen),
    .exe_bdepen (exe_bdepen),
    .stall      (stall),
    .flush      (flush),
    .id_bubble  (id_bubble),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  // Model: which instruction sits in EXE and in MEM, plus expected outputs.
  logic        ex_valid_w, ex_load;
  logic [4:0]  ex_dst;
  logic        mem_valid_w;
  logic [4:0]  mem_dst;
  logic [1:0]  m_sa, m_sb;
  int          m_scnt, m_fcnt;
  logic        last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Does the instruction in EXE (k=0) or MEM (k=1) produce register r?
  function automatic logic produces(input int k, input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (k == 0) return ex_valid_w && ex_dst == r;
    return mem_valid_w && mem_dst == r;
  endfunction

  function automatic logic [1:0] pick(input logic ovr, input logic use_r, input logic [4:0] r);
    if (ovr) return 2'b01;
    if (!use_r) return 2'b00;
    for (int k = 0; k < 2; k++) begin
      if (produces(k, r)) return (k == 0) ? 2'b10 : 2'b11;
    end
    return 2'b00;
  endfunction

  function automatic id_t op(input int rd, input int rs, input int rt, input bit wreg,
                             input bit m2reg, input bit use_rs, input bit use_rt);
    id_t x;
    x = '0;
    x.rd = 5'(rd); x.rs = 5'(rs); x.rt = 5'(rt);
    x.wreg = wreg; x.m2reg = m2reg; x.use_rs = use_rs; x.use_rt = use_rt;
    return x;
  endfunction

  // Present one ID instruction for one cycle; check outputs before and after the edge.
  task automatic drive(input id_t i);
    logic e_stall, e_flush, e_bub, dep;
    logic [1:0] e_sa, e_sb;
    rst = i.rst; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    id_use_rs = i.use_rs; id_use_rt = i.use_rt; id_wreg = i.wreg; id_m2reg = i.m2reg;
    id_shift = i.shift; id_aluimm = i.aluimm; exe_z = i.z;
    #1;
    dep = (i.use_rs && produces(0, i.rs)) || (i.use_rt && produces(0, i.rt));
    e_flush = !i.rst && i.z;
    e_stall = !i.rst && !i.z && ex_load && dep;
    e_bub   = e_stall || e_flush;
    e_sa = pick(i.shift, i.use_rs, i.rs);
    e_sb = pick(i.aluimm, i.use_rt, i.rt);
    check("stall", 32'(stall), 32'(e_stall));
    check("flush", 32'(flush), 32'(e_flush));
    check("id_bubble", 32'(id_bubble), 32'(e_bub));
    @(posedge clk);
    if (i.rst) begin
      ex_valid_w = 0; ex_load = 0; ex_dst = 0; mem_valid_w = 0; mem_dst = 0;
      m_sa = 0; m_sb = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      mem_valid_w = ex_valid_w; mem_dst = ex_dst;
      if (e_bub) begin
        ex_valid_w = 0; ex_load = 0; m_sa = 0; m_sb = 0;
      end else begin
        ex_valid_w = i.wreg; ex_load = i.m2reg; ex_dst = i.rd; m_sa = e_sa; m_sb = e_sb;
      end
      if (e_stall && m_scnt < 65535) m_scnt++;
      if (e_flush && m_fcnt < 65535) m_fcnt++;
    end
    last_stall = e_stall;
    #1;
    check("exe_adepen", 32'(exe_adepen), 32'(m_sa));
    check("exe_bdepen", 32'(exe_bdepen), 32'(m_sb));
    check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    check("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
  endtask

  initial begin
    id_t x, cur;
    int sc0;
    ex_valid_w = 0; ex_load = 0; ex_dst = 0; mem_valid_w = 0; mem_dst = 0;
    m_sa = 0; m_sb = 0; m_scnt = 0; m_fcnt = 0; last_stall = 0;
    rst = 1; id_rs = 0; id_rt = 0; id_rd = 0; id_use_rs = 0; id_use_rt = 0;
    id_wreg = 0; id_m2reg = 0; id_shift = 0; id_aluimm = 0; exe_z = 0;
    @(posedge clk); #1;
    x = '0; x.rst = 1;
    drive(x);
    drive(x);

    // Forward from EXE on A.
    drive(op(3, 0, 0, 1, 0, 0, 0));
    drive(op(4, 3, 0, 1, 0, 1, 0));
    check("dir_fwd_ex_a", 32'(exe_adepen), 32'h2);
    // r3 now in MEM: forward from WB on B.
    drive(op(6, 0, 3, 1, 0, 0, 1));
    check("dir_fwd_wb_b", 32'(exe_bdepen), 32'h3);
    // r3 in both EXE and MEM: nearest wins.
    drive(op(3, 0, 0, 1, 0, 0, 0));
    drive(op(3, 0, 0, 1, 0, 0, 0));
    drive(op(8, 0, 3, 1, 0, 0, 1));
    check("dir_nearest_b", 32'(exe_bdepen), 32'h2);
    // Load-use: one stall cycle, then forward from WB.
    sc0 = m_scnt;
    drive(op(5, 0, 0, 1, 1, 0, 0));
    drive(op(7, 5, 0, 1, 0, 1, 0));
    check("dir_loaduse_cnt", 32'(stall_cnt), 32'(sc0 + 1));
    drive(op(7, 5, 0, 1, 0, 1, 0));
    check("dir_after_stall_a", 32'(exe_adepen), 32'h3);
    // r0 destination never forwards or stalls.
    drive(op(0, 0, 0, 1, 1, 0, 0));
    drive(op(9, 0, 0, 1, 0, 1, 1));
    check("dir_r0_a", 32'(exe_adepen), 32'h0);
    // Branch flush over load-use.
    drive(op(5, 0, 0, 1, 1, 0, 0));
    x = op(7, 5, 0, 1, 0, 1, 0); x.z = 1;
    drive(x);
    drive(op(10, 7, 7, 0, 0, 1, 1));
    check("dir_flush_no_fwd", 32'(exe_adepen), 32'h0);

    // Randomized phase; a stalled instruction is re-presented like a held IF/ID.
    cur = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!last_stall) begin
        cur.rs = 5'($urandom_range(0, 3));
        cur.rt = 5'($urandom_range(0, 3));
        cur.rd = 5'($urandom_range(0, 3));
        cur.use_rs = 1'($urandom_range(0, 3) != 0);
        cur.use_rt = 1'($urandom_range(0, 1));
        cur.wreg   = 1'($urandom_range(0, 3) != 0);
        cur.m2reg  = 1'($urandom_range(0, 2) == 0);
        cur.shift  = 1'($urandom_range(0, 7) == 0);
        cur.aluimm = 1'($urandom_range(0, 3) == 0);
      end
      cur.z   = 1'($urandom_range(0, 7) == 0);
      cur.rst = 1'($urandom_range(0, 99) == 0);
      drive(cur);
    end

    // Flush counter saturation.
    x = '0; x.rst = 1;
    drive(x);
    x = '0; x.z = 1;
    for (int n = 0; n < 65540; n++) drive(x);
    check("flush_cnt_sat", 32'(flush_cnt), 32'hFFFF);

    // Reset while stalled clears everything.
    drive(op(5, 0, 0, 1, 1, 0, 0));
    x = op(7, 5, 0, 1, 0, 1, 0);
    drive(x);
    check("pre_rst_stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    drive(op(5, 0, 0, 1, 1, 0, 0));
    rst = 1; id_rs = 5; id_use_rs = 1; id_m2reg = 0; id_rd = 7;
    #1;
    check("stall_masked_by_rst", 32'(stall), 32'h0);
    x.rst = 1;
    drive(x);
    check("rst_flush_cnt", 32'(flush_cnt), 32'h0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    x.rst = 0;
    drive(x);
    check("post_rst_no_stall_sa", 32'(exe_adepen), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
